// File: rtl/dps_router_pkg.sv
// Purpose: shared types and width helpers for the DPS device router.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dps_router_pkg;

    typedef enum logic [1:0] {
        RQ_IDLE    = 2'd0,
        RQ_RD_WAIT = 2'd1,
        RQ_ERR     = 2'd2
    } rq_state_e;

    typedef enum logic [1:0] {
        IQ_IDLE = 2'd0,
        IQ_REQ  = 2'd1,
        IQ_ACK  = 2'd2
    } iq_state_e;

    // Width of a slot index; a single slot still needs one bit.
    function automatic int slot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the read-wait counter, able to hold 0..timeout.
    function automatic int timeout_cnt_w(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/dps_prio_enc.sv
// Purpose: lowest-index-first priority encoder (vec -> any, idx).
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: iVEC request vector; oANY set when any bit set; oIDX index of lowest set bit (0 when none).
module dps_prio_enc
    import dps_router_pkg::*;
#(
    parameter int P_N   = 4,
    parameter int IDX_W = slot_idx_w(P_N)
) (
    input  logic [P_N-1:0]   iVEC,
    output logic             oANY,
    output logic [IDX_W-1:0] oIDX
);

    always_comb begin
        oANY = |iVEC;
        oIDX = '0;
        // Scan downward so the lowest set bit is the last to overwrite.
        for (int i = P_N - 1; i >= 0; i--) begin
            if (iVEC[i]) oIDX = IDX_W'(i);
        end
    end

endmodule

// File: rtl/dps_dev_router.sv
// Purpose: decode DPS requests onto P_SLOTS base/mask windows, collect read data, arbitrate slot IRQs.
// Latency: write hit 0 cycles; read = slot latency (>=1, timeout error at P_TIMEOUT); miss error 1 cycle.
// Backpressure: oDPS_BUSY while a read/error is outstanding or any slot reports busy.
// Ports: iDPS_* core request / oDPS_* response and IRQ; oSLOT_* broadcast request and one-hot strobes;
//        iSLOT_* per-slot windows, busy, read data and IRQ levels; oSLOT_IRQ_ACK one-cycle ack pulse.
module dps_dev_router
    import dps_router_pkg::*;
#(
    parameter int P_SLOTS     = 4,
    parameter int P_DATA_W    = 32,
    parameter int P_TIMEOUT   = 255,
    parameter int P_IRQ_BASE  = 36,
    parameter int P_IRQ_NUM_W = 6
) (
    input  logic                         iCLOCK,
    input  logic                         inRESET,
    input  logic                         iDPS_REQ,
    output logic                         oDPS_BUSY,
    input  logic                         iDPS_RW,
    input  logic [31:0]                  iDPS_ADDR,
    input  logic [P_DATA_W-1:0]          iDPS_DATA,
    output logic                         oDPS_VALID,
    output logic                         oDPS_ERR,
    output logic [P_DATA_W-1:0]          oDPS_DATA,
    input  logic [P_SLOTS*32-1:0]        iSLOT_BASE,
    input  logic [P_SLOTS*32-1:0]        iSLOT_MASK,
    output logic [P_SLOTS-1:0]           oSLOT_REQ,
    input  logic [P_SLOTS-1:0]           iSLOT_BUSY,
    output logic                         oSLOT_RW,
    output logic [31:0]                  oSLOT_ADDR,
    output logic [P_DATA_W-1:0]          oSLOT_DATA,
    input  logic [P_SLOTS-1:0]           iSLOT_VALID,
    input  logic [P_SLOTS*P_DATA_W-1:0]  iSLOT_DATA,
    input  logic [P_SLOTS-1:0]           iSLOT_IRQ,
    output logic [P_SLOTS-1:0]           oSLOT_IRQ_ACK,
    output logic                         oDPS_IRQ_REQ,
    output logic [P_IRQ_NUM_W-1:0]       oDPS_IRQ_NUM,
    input  logic                         iDPS_IRQ_ACK
);

    localparam int IDX_W = slot_idx_w(P_SLOTS);
    localparam int CNT_W = timeout_cnt_w(P_TIMEOUT);
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(P_TIMEOUT - 1);
    localparam logic [P_IRQ_NUM_W-1:0] IRQ_BASE_V = P_IRQ_NUM_W'(P_IRQ_BASE);

    rq_state_e        req_state_q, req_state_d;
    logic [IDX_W-1:0] slot_idx_q,  slot_idx_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             rw_q,        rw_d;
    iq_state_e        irq_state_q, irq_state_d;
    logic [IDX_W-1:0] irq_idx_q,   irq_idx_d;

    logic [P_SLOTS-1:0] hit;
    logic               dec_any, irq_any;
    logic [IDX_W-1:0]   dec_idx, irq_idx;
    logic               accept;

    always_comb begin
        for (int i = 0; i < P_SLOTS; i++) begin
            hit[i] = ((iDPS_ADDR & iSLOT_MASK[32*i +: 32]) ==
                      (iSLOT_BASE[32*i +: 32] & iSLOT_MASK[32*i +: 32]));
        end
    end

    dps_prio_enc #(.P_N(P_SLOTS), .IDX_W(IDX_W)) u_dec_enc (
        .iVEC (hit),
        .oANY (dec_any),
        .oIDX (dec_idx)
    );

    dps_prio_enc #(.P_N(P_SLOTS), .IDX_W(IDX_W)) u_irq_enc (
        .iVEC (iSLOT_IRQ),
        .oANY (irq_any),
        .oIDX (irq_idx)
    );

    assign oSLOT_RW   = iDPS_RW;
    assign oSLOT_ADDR = iDPS_ADDR;
    assign oSLOT_DATA = iDPS_DATA;

    assign oDPS_BUSY = (req_state_q != RQ_IDLE) | (|iSLOT_BUSY);
    // Nothing can be accepted while reset holds the FSM, so no strobe leaks out.
    assign accept    = iDPS_REQ & ~oDPS_BUSY & inRESET;

    // Request path.
    always_comb begin
        req_state_d = req_state_q;
        slot_idx_d  = slot_idx_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        oSLOT_REQ   = '0;
        oDPS_VALID  = 1'b0;
        oDPS_ERR    = 1'b0;
        oDPS_DATA   = '0;
        unique case (req_state_q)
            RQ_IDLE: begin
                if (accept) begin
                    if (dec_any) begin
                        oSLOT_REQ = P_SLOTS'(1) << dec_idx;
                        if (!iDPS_RW) begin
                            req_state_d = RQ_RD_WAIT;
                            slot_idx_d  = dec_idx;
                            cnt_d       = '0;
                        end
                    end else begin
                        req_state_d = RQ_ERR;
                        rw_d        = iDPS_RW;
                    end
                end
            end
            RQ_RD_WAIT: begin
                // Only the latched slot can complete; valid beats a same-cycle timeout.
                if (iSLOT_VALID[slot_idx_q]) begin
                    oDPS_VALID  = 1'b1;
                    oDPS_DATA   = iSLOT_DATA[slot_idx_q*P_DATA_W +: P_DATA_W];
                    req_state_d = RQ_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    oDPS_VALID  = 1'b1;
                    oDPS_ERR    = 1'b1;
                    req_state_d = RQ_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RQ_ERR: begin
                // Writes that miss still report the error, but with no read valid.
                oDPS_ERR    = 1'b1;
                oDPS_VALID  = ~rw_q;
                req_state_d = RQ_IDLE;
            end
            default: req_state_d = RQ_IDLE;
        endcase
    end

    // IRQ path, independent of request traffic.
    always_comb begin
        irq_state_d   = irq_state_q;
        irq_idx_d     = irq_idx_q;
        oDPS_IRQ_REQ  = 1'b0;
        oDPS_IRQ_NUM  = '0;
        oSLOT_IRQ_ACK = '0;
        unique case (irq_state_q)
            IQ_IDLE: begin
                if (irq_any) begin
                    irq_idx_d   = irq_idx;
                    irq_state_d = IQ_REQ;
                end
            end
            IQ_REQ: begin
                oDPS_IRQ_REQ = 1'b1;
                oDPS_IRQ_NUM = IRQ_BASE_V + P_IRQ_NUM_W'(irq_idx_q);
                if (iDPS_IRQ_ACK) irq_state_d = IQ_ACK;
            end
            IQ_ACK: begin
                oSLOT_IRQ_ACK = P_SLOTS'(1) << irq_idx_q;
                irq_state_d   = IQ_IDLE;
            end
            default: irq_state_d = IQ_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            req_state_q <= RQ_IDLE;
            slot_idx_q  <= '0;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            irq_state_q <= IQ_IDLE;
            irq_idx_q   <= '0;
        end else begin
            req_state_q <= req_state_d;
            slot_idx_q  <= slot_idx_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            irq_state_q <= irq_state_d;
            irq_idx_q   <= irq_idx_d;
        end
    end

endmodule

// File: tb/tb_dps_dev_router.sv
module tb_dps_dev_router;

    localparam int NS = 4;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dps_req, dps_busy, dps_rw;
    logic [31:0]      dps_addr;
    logic [DW-1:0]    dps_wdata;
    logic             dps_valid, dps_err;
    logic [DW-1:0]    dps_rdata;
    logic [NS*32-1:0] slot_base, slot_mask;
    logic [NS-1:0]    slot_req, slot_busy, slot_valid, slot_irq, slot_irq_ack;
    logic             slot_rw;
    logic [31:0]      slot_addr;
    logic [DW-1:0]    slot_wdata;
    logic [NS*DW-1:0] slot_rdata;
    logic             irq_req, irq_ack;
    logic [5:0]       irq_num;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dps_dev_router #(
        .P_SLOTS(NS), .P_DATA_W(DW), .P_TIMEOUT(8), .P_IRQ_BASE(36), .P_IRQ_NUM_W(6)
    ) dut (
        .iCLOCK(clk), .inRESET(rst_n),
        .iDPS_REQ(dps_req), .oDPS_BUSY(dps_busy), .iDPS_RW(dps_rw),
        .iDPS_ADDR(dps_addr), .iDPS_DATA(dps_wdata),
        .oDPS_VALID(dps_valid), .oDPS_ERR(dps_err), .oDPS_DATA(dps_rdata),
        .iSLOT_BASE(slot_base), .iSLOT_MASK(slot_mask),
        .oSLOT_REQ(slot_req), .iSLOT_BUSY(slot_busy),
        .oSLOT_RW(slot_rw), .oSLOT_ADDR(slot_addr), .oSLOT_DATA(slot_wdata),
        .iSLOT_VALID(slot_valid), .iSLOT_DATA(slot_rdata),
        .iSLOT_IRQ(slot_irq), .oSLOT_IRQ_ACK(slot_irq_ack),
        .oDPS_IRQ_REQ(irq_req), .oDPS_IRQ_NUM(irq_num), .iDPS_IRQ_ACK(irq_ack)
    );

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle; outputs settle before the check point.
    task automatic drive_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
        dps_req = 1'b1; dps_rw = rw; dps_addr = addr; dps_wdata = wd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dps_req = 1'b1; dps_rw = 1'b0; dps_addr = 32'h104; dps_wdata = '0;
        slot_busy = '0; slot_valid = '0; slot_rdata = '0; slot_irq = '0; irq_ack = 1'b0;
        slot_base = {32'h200, 32'h040, 32'h100, 32'h000};
        slot_mask = {32'hF00, 32'hFC0, 32'hFF0, 32'hF80};
        #12;
        n_checks++; if (slot_req !== 4'b0000) begin n_fails++; $display("FAIL rst_slot_req: got %b want 0000", slot_req); end
        n_checks++; if ({dps_busy, dps_valid, dps_err, irq_req} !== 4'b0000) begin n_fails++; $display("FAIL rst_flags: got %b want 0000", {dps_busy, dps_valid, dps_err, irq_req}); end
        n_checks++; if ({dps_rdata, irq_num, slot_irq_ack} !== '0) begin n_fails++; $display("FAIL rst_data: got %h/%0d/%b want 0", dps_rdata, irq_num, slot_irq_ack); end
        dps_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_hit();
        drive_req(1'b0, 32'h104, 32'h0);
        n_checks++; if (slot_req !== 4'b0010) begin n_fails++; $display("FAIL rd_strobe: got %b want 0010", slot_req); end
        n_checks++; if (slot_addr !== 32'h104 || slot_rw !== 1'b0) begin n_fails++; $display("FAIL rd_passthru: got %h/%b want 104/0", slot_addr, slot_rw); end
        tick(); dps_req = 1'b0; #1;
        n_checks++; if (dps_busy !== 1'b1 || dps_valid !== 1'b0) begin n_fails++; $display("FAIL rd_c1: busy=%b valid=%b want 1/0", dps_busy, dps_valid); end
        // Valid from a non-addressed slot must be ignored.
        tick(); slot_valid = 4'b0001; slot_rdata[0 +: 32] = 32'hDEAD_BEEF; #1;
        n_checks++; if (dps_busy !== 1'b1 || dps_valid !== 1'b0) begin n_fails++; $display("FAIL rd_c2_other: busy=%b valid=%b want 1/0", dps_busy, dps_valid); end
        tick(); slot_valid = 4'b0010; slot_rdata[32 +: 32] = 32'hA5A5_0001; #1;
        n_checks++; if (dps_valid !== 1'b1 || dps_err !== 1'b0 || dps_busy !== 1'b1) begin n_fails++; $display("FAIL rd_c3: valid=%b err=%b busy=%b want 1/0/1", dps_valid, dps_err, dps_busy); end
        n_checks++; if (dps_rdata !== 32'hA5A5_0001) begin n_fails++; $display("FAIL rd_data: got %h want a5a50001", dps_rdata); end
        tick(); slot_valid = '0; #1;
        n_checks++; if (dps_busy !== 1'b0 || dps_valid !== 1'b0) begin n_fails++; $display("FAIL rd_done: busy=%b valid=%b want 0/0", dps_busy, dps_valid); end
    endtask

    task automatic test_miss();
        drive_req(1'b0, 32'h300, 32'h0);
        n_checks++; if (slot_req !== 4'b0000) begin n_fails++; $display("FAIL miss_rd_strobe: got %b want 0000", slot_req); end
        tick(); dps_req = 1'b0; #1;
        n_checks++; if ({dps_valid, dps_err} !== 2'b11 || dps_rdata !== '0) begin n_fails++; $display("FAIL miss_rd_resp: valid/err=%b data=%h want 11/0", {dps_valid, dps_err}, dps_rdata); end
        tick(); #1;
        n_checks++; if ({dps_valid, dps_err, dps_busy} !== 3'b000) begin n_fails++; $display("FAIL miss_rd_idle: got %b want 000", {dps_valid, dps_err, dps_busy}); end
        drive_req(1'b1, 32'h300, 32'h1234);
        n_checks++; if (slot_req !== 4'b0000) begin n_fails++; $display("FAIL miss_wr_strobe: got %b want 0000", slot_req); end
        tick(); dps_req = 1'b0; #1;
        n_checks++; if ({dps_valid, dps_err} !== 2'b01) begin n_fails++; $display("FAIL miss_wr_resp: valid/err=%b want 01", {dps_valid, dps_err}); end
        tick();
    endtask

    task automatic test_write_overlap_busy();
        // 0x050 lies in both slot 0 and slot 2 windows.
        drive_req(1'b1, 32'h050, 32'hCAFE_F00D);
        n_checks++; if (slot_req !== 4'b0001) begin n_fails++; $display("FAIL overlap_strobe: got %b want 0001", slot_req); end
        n_checks++; if (slot_wdata !== 32'hCAFE_F00D || slot_rw !== 1'b1) begin n_fails++; $display("FAIL wr_passthru: got %h/%b want cafef00d/1", slot_wdata, slot_rw); end
        tick(); dps_req = 1'b0; #1;
        n_checks++; if ({dps_busy, dps_valid, dps_err} !== 3'b000) begin n_fails++; $display("FAIL wr_no_resp: got %b want 000", {dps_busy, dps_valid, dps_err}); end
        slot_busy = 4'b1000;
        drive_req(1'b0, 32'h104, 32'h0);
        n_checks++; if (dps_busy !== 1'b1 || slot_req !== 4'b0000) begin n_fails++; $display("FAIL slot_busy: busy=%b strobe=%b want 1/0000", dps_busy, slot_req); end
        tick(); dps_req = 1'b0; slot_busy = '0; #1;
        n_checks++; if ({dps_busy, dps_valid, dps_err} !== 3'b000) begin n_fails++; $display("FAIL busy_not_taken: got %b want 000", {dps_busy, dps_valid, dps_err}); end
    endtask

    task automatic test_timeout();
        drive_req(1'b0, 32'h200, 32'h0);
        n_checks++; if (slot_req !== 4'b1000) begin n_fails++; $display("FAIL to_strobe: got %b want 1000", slot_req); end
        tick(); dps_req = 1'b0;
        for (int c = 1; c < 8; c++) begin
            #1;
            n_checks++; if (dps_valid !== 1'b0) begin n_fails++; $display("FAIL to_early c%0d: valid=%b want 0", c, dps_valid); end
            tick();
        end
        #1;
        n_checks++; if ({dps_valid, dps_err} !== 2'b11 || dps_rdata !== '0) begin n_fails++; $display("FAIL to_resp: valid/err=%b data=%h want 11/0", {dps_valid, dps_err}, dps_rdata); end
        tick(); slot_valid = 4'b1000; slot_rdata[96 +: 32] = 32'h5555_AAAA; #1;
        n_checks++; if ({dps_valid, dps_err, dps_busy} !== 3'b000) begin n_fails++; $display("FAIL to_late: got %b want 000", {dps_valid, dps_err, dps_busy}); end
        drive_req(1'b0, 32'h104, 32'h0);
        n_checks++; if (slot_req !== 4'b0010) begin n_fails++; $display("FAIL to_new_req: got %b want 0010", slot_req); end
        tick(); dps_req = 1'b0; slot_valid = 4'b0010; slot_rdata[32 +: 32] = 32'h0000_1111; #1;
        n_checks++; if (dps_valid !== 1'b1 || dps_rdata !== 32'h0000_1111) begin n_fails++; $display("FAIL to_new_resp: valid=%b data=%h want 1/00001111", dps_valid, dps_rdata); end
        tick(); slot_valid = '0;
        // Valid arriving on the timeout cycle wins with no error.
        drive_req(1'b0, 32'h200, 32'h0);
        tick(); dps_req = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        slot_valid = 4'b1000; slot_rdata[96 +: 32] = 32'h7777_0008; #1;
        n_checks++; if ({dps_valid, dps_err} !== 2'b10 || dps_rdata !== 32'h7777_0008) begin n_fails++; $display("FAIL to_tie: valid/err=%b data=%h want 10/77770008", {dps_valid, dps_err}, dps_rdata); end
        tick(); slot_valid = '0;
    endtask

    task automatic test_irq();
        slot_irq = 4'b1010; #1;
        n_checks++; if (irq_req !== 1'b0) begin n_fails++; $display("FAIL irq_c0: req=%b want 0", irq_req); end
        tick(); #1;
        n_checks++; if (irq_req !== 1'b1 || irq_num !== 6'd37) begin n_fails++; $display("FAIL irq_first: req=%b num=%0d want 1/37", irq_req, irq_num); end
        irq_ack = 1'b1;
        tick(); irq_ack = 1'b0; #1;
        n_checks++; if (slot_irq_ack !== 4'b0010 || irq_req !== 1'b0) begin n_fails++; $display("FAIL irq_ack1: ack=%b req=%b want 0010/0", slot_irq_ack, irq_req); end
        tick(); slot_irq = 4'b1000; #1;
        n_checks++; if (slot_irq_ack !== 4'b0000 || irq_req !== 1'b0) begin n_fails++; $display("FAIL irq_gap: ack=%b req=%b want 0000/0", slot_irq_ack, irq_req); end
        tick(); #1;
        n_checks++; if (irq_req !== 1'b1 || irq_num !== 6'd39) begin n_fails++; $display("FAIL irq_second: req=%b num=%0d want 1/39", irq_req, irq_num); end
        irq_ack = 1'b1;
        tick(); irq_ack = 1'b0; #1;
        n_checks++; if (slot_irq_ack !== 4'b1000) begin n_fails++; $display("FAIL irq_ack2: ack=%b want 1000", slot_irq_ack); end
        tick(); slot_irq = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        slot_irq = 4'b0001;
        drive_req(1'b0, 32'h104, 32'h0);
        tick(); dps_req = 1'b0; #1;
        n_checks++; if (dps_busy !== 1'b1 || irq_req !== 1'b1 || irq_num !== 6'd36) begin n_fails++; $display("FAIL pre_rst: busy=%b req=%b num=%0d want 1/1/36", dps_busy, irq_req, irq_num); end
        #2; rst_n = 1'b0; #1;
        n_checks++; if ({dps_busy, dps_valid, dps_err, irq_req, irq_num, slot_req, slot_irq_ack, dps_rdata} !== '0) begin n_fails++; $display("FAIL mid_rst: busy=%b req=%b num=%0d", dps_busy, irq_req, irq_num); end
        slot_irq = '0;
        tick(); rst_n = 1'b1;
        tick(); slot_valid = 4'b0010; slot_rdata[32 +: 32] = 32'h9999_9999; #1;
        n_checks++; if ({dps_valid, dps_err, irq_req} !== 3'b000) begin n_fails++; $display("FAIL post_rst: valid/err/irq=%b want 000", {dps_valid, dps_err, irq_req}); end
        tick(); slot_valid = '0;
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_miss();
        test_write_overlap_busy();
        test_timeout();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dps_dev_router.md
# dps_dev_router

Parametrised device-side router for the DPS peripheral subsystem. It generalises the fixed DPS address decode, read-wait and IRQ-number logic to `P_SLOTS` device slots. Each slot has a runtime base/mask window. Unmapped addresses get an error response, and hung reads end with a timeout error. The block sits between the core's DPS request port and the individual devices (UTIM64, SCI, MIMSR, LSFLAGS, future slots), and it drives the core interrupt request.

## Interface
Parameters:
- `P_SLOTS`, 4, number of device slots (1–16).
- `P_DATA_W`, 32, data width.
- `P_TIMEOUT`, 255, read-wait cycles before an error response (≥1).
- `P_IRQ_BASE`, 36, IRQ number reported for slot 0.
- `P_IRQ_NUM_W`, 6, IRQ number width.

Ports (one clock; reset is asynchronous and active-low):
- `iCLOCK` in 1: clock.
- `inRESET` in 1: reset, asynchronous, active-low.
- `iDPS_REQ` in 1: request.
- `oDPS_BUSY` out 1: request not accepted.
- `iDPS_RW` in 1: 1 = write.
- `iDPS_ADDR` in 32: byte address.
- `iDPS_DATA` in `P_DATA_W`: write data.
- `oDPS_VALID` out 1: read response.
- `oDPS_ERR` out 1: error (miss or timeout).
- `oDPS_DATA` out `P_DATA_W`: read data.
- `iSLOT_BASE` in `P_SLOTS*32`: per-slot base, slot i at [32i+31:32i]; static during traffic.
- `iSLOT_MASK` in `P_SLOTS*32`: per-slot compare mask.
- `oSLOT_REQ` out `P_SLOTS`: one-hot request strobe.
- `iSLOT_BUSY` in `P_SLOTS`: slot busy.
- `oSLOT_RW` out 1, `oSLOT_ADDR` out 32, `oSLOT_DATA` out `P_DATA_W`: broadcast copies of the request.
- `iSLOT_VALID` in `P_SLOTS`: slot read valid.
- `iSLOT_DATA` in `P_SLOTS*P_DATA_W`: slot read data.
- `iSLOT_IRQ` in `P_SLOTS`: level interrupt request.
- `oSLOT_IRQ_ACK` out `P_SLOTS`: one-cycle ack pulse.
- `oDPS_IRQ_REQ` out 1: interrupt to core.
- `oDPS_IRQ_NUM` out `P_IRQ_NUM_W`: interrupt number.
- `iDPS_IRQ_ACK` in 1: core ack.

## Operation
Decode:
- Slot i hits when `(iDPS_ADDR & MASK[i]) == (BASE[i] & MASK[i])`.
- When several slots hit, the lowest index wins.

Acceptance:
- `oDPS_BUSY = (req_state != RQ_IDLE) | (|iSLOT_BUSY)`.
- A request is accepted when `iDPS_REQ & !oDPS_BUSY`.

Hit handling:
- `oSLOT_REQ[hit]` is asserted combinationally in the accept cycle.
- `oSLOT_RW`, `oSLOT_ADDR` and `oSLOT_DATA` are always pass-through copies of the request.
- A write hit completes in the accept cycle; there is no response.
- A read hit moves to `RQ_RD_WAIT` and latches the slot index and a timeout counter cleared to 0.

Miss handling (no slot hits):
- No `oSLOT_REQ` is asserted; the state moves to `RQ_ERR`.
- In the next cycle `oDPS_ERR=1` and `oDPS_VALID=!rw` (the rw value is latched), with `oDPS_DATA=0`; then the state returns to `RQ_IDLE`.

`RQ_RD_WAIT`:
- `iSLOT_VALID[latched]` gives `oDPS_VALID=1` and `oDPS_DATA = iSLOT_DATA[latched]` (combinational), then `RQ_IDLE`.
- Otherwise the counter increments. At counter == `P_TIMEOUT-1` without valid: `oDPS_VALID=1`, `oDPS_ERR=1`, `oDPS_DATA=0`, then `RQ_IDLE`.
- Valid and timeout in the same cycle: valid wins and `oDPS_ERR=0`.
- Valid from any other slot is ignored. A late valid after a timeout is ignored.

IRQ FSM (`IQ_IDLE`, `IQ_REQ`, `IQ_ACK`):
- `IQ_IDLE`: when any `iSLOT_IRQ` is set, latch the lowest set index and go to `IQ_REQ`.
- `IQ_REQ`: `oDPS_IRQ_REQ=1`, `oDPS_IRQ_NUM = P_IRQ_BASE + idx` (modulo 2^`P_IRQ_NUM_W`). On `iDPS_IRQ_ACK` go to `IQ_ACK`.
- `IQ_ACK`: `oSLOT_IRQ_ACK[idx]=1` for one cycle, then `IQ_IDLE`. The slot must drop its IRQ on the edge that samples the ack.
- The IRQ FSM is independent of request traffic.

Reset:
- All outputs are driven to 0 except the pass-through copies; both FSMs return to idle; counters clear.
- A reset during `RQ_RD_WAIT` drops the transaction silently.

## Timing
- Write hit: 0-cycle acceptance, no response.
- Read hit: response no earlier than 1 cycle after accept, equal to slot latency, at most `P_TIMEOUT` cycles.
- Miss: error exactly 1 cycle after accept.
- IRQ: `oDPS_IRQ_REQ` is asserted 1 cycle after `iSLOT_IRQ` rises while idle. `oSLOT_IRQ_ACK` is 1 cycle after `iDPS_IRQ_ACK`. Minimum 3 cycles between successive IRQ grants.

## Structure
- Package `dps_router_pkg`: request state enum (`RQ_IDLE`, `RQ_RD_WAIT`, `RQ_ERR`), IRQ state enum, timeout counter width `$clog2(P_TIMEOUT+1)`, slot-index width function.
- Sub-module `dps_prio_enc`: parametrised lowest-index-first encoder (inputs: vector; outputs: any, index). It is instantiated twice, once for decode and once for IRQ.

## Test plan
- Slots 0 at 0x000/mask 0xF80, 1 at 0x100/mask 0xFF0; read 0x104, slot 1 valid after 3 cycles with 0xA5A5_0001 -> `oDPS_VALID` at cycle 3, data 0xA5A5_0001, `oDPS_ERR=0`, busy throughout.
- Read 0x300 (no hit) -> no `oSLOT_REQ`; next cycle `oDPS_VALID=1`, `oDPS_ERR=1`, data 0. Write 0x300 -> `oDPS_ERR=1`, `oDPS_VALID=0`.
- `P_TIMEOUT=8`, slot never responds -> error response at cycle 8. A later slot valid produces no output, and a new request is accepted.
- `iSLOT_IRQ=4'b1010` -> `oDPS_IRQ_NUM=37`. After ack, `oSLOT_IRQ_ACK=4'b0010` for one cycle; slot 1 drops its IRQ -> next grant `oDPS_IRQ_NUM=39`.
- Overlapping windows for slots 0 and 2 -> slot 0 strobed only. `iSLOT_BUSY[3]=1` -> `oDPS_BUSY=1`, no strobe.
- Assert `inRESET` mid-`RQ_RD_WAIT` and during `IQ_REQ` -> all outputs 0 immediately; no response after release.
